// File: rtl/gbf_read_streamer.sv
// Read engine for the quad-port global buffer: fetches up to four words per cycle
// into a small FIFO and streams them out one word per cycle over valid/ready.
module gbf_read_streamer #(
    parameter int WIDTH      = 32,
    parameter int HEIGHT     = 48,
    parameter int AW         = $clog2(HEIGHT),
    parameter int LW         = $clog2(HEIGHT + 1),
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [AW-1:0]    base_addr,
    input  logic [LW-1:0]    len,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    addr_a,
    output logic [AW-1:0]    addr_b,
    output logic [AW-1:0]    addr_c,
    output logic [AW-1:0]    addr_d,
    input  logic [WIDTH-1:0] q_a,
    input  logic [WIDTH-1:0] q_b,
    input  logic [WIDTH-1:0] q_c,
    input  logic [WIDTH-1:0] q_d,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    cur_q, cur_d;
    logic [LW-1:0]    rem_q, rem_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [AW-1:0]    addr_q    [4];
    logic [AW-1:0]    addr_lane [4];
    logic [AW:0]      lane_sum  [4];
    logic [PW:0]      wr_idx    [4];
    logic [WIDTH-1:0] q_lane    [4];
    logic [WIDTH-1:0] mem_q     [FIFO_DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d, free_slots;
    logic [2:0]       n;
    logic [LW-1:0]    len_clamped;
    logic             fetch, pop;
    logic [AW:0]      cur_sum;
    logic [PW:0]      wr_sum, rd_sum;

    assign q_lane[0] = q_a;
    assign q_lane[1] = q_b;
    assign q_lane[2] = q_c;
    assign q_lane[3] = q_d;

    assign len_clamped = (len > LW'(HEIGHT)) ? LW'(HEIGHT) : len;
    assign n           = (rem_q > LW'(4)) ? 3'd4 : rem_q[2:0];
    // Free slots are taken before this cycle's pop, so a fetch never relies on it.
    assign free_slots  = CW'(FIFO_DEPTH) - cnt_q;
    assign fetch       = (state_q == S_FETCH) && (free_slots >= CW'(n));
    assign m_valid     = (cnt_q != CW'(0));
    assign pop         = m_valid && m_ready;
    assign m_data      = m_valid ? mem_q[rd_q] : '0;
    assign busy        = busy_q;
    assign done        = done_q;

    assign addr_a = addr_lane[0];
    assign addr_b = addr_lane[1];
    assign addr_c = addr_lane[2];
    assign addr_d = addr_lane[3];

    // Lanes not used by the current fetch keep their last address.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lane_sum[k] = {1'b0, cur_q} + (AW+1)'(k);
            if (lane_sum[k] >= (AW+1)'(HEIGHT)) lane_sum[k] = lane_sum[k] - (AW+1)'(HEIGHT);
            addr_lane[k] = (fetch && (3'(k) < n)) ? lane_sum[k][AW-1:0] : addr_q[k];
            wr_idx[k] = {1'b0, wr_q} + (PW+1)'(k);
            if (wr_idx[k] >= (PW+1)'(FIFO_DEPTH)) wr_idx[k] = wr_idx[k] - (PW+1)'(FIFO_DEPTH);
        end
    end

    always_comb begin
        cur_sum = {1'b0, cur_q} + (AW+1)'(n);
        if (cur_sum >= (AW+1)'(HEIGHT)) cur_sum = cur_sum - (AW+1)'(HEIGHT);
        wr_sum = {1'b0, wr_q} + (PW+1)'(n);
        if (wr_sum >= (PW+1)'(FIFO_DEPTH)) wr_sum = wr_sum - (PW+1)'(FIFO_DEPTH);
        rd_sum = {1'b0, rd_q} + (PW+1)'(1);
        if (rd_sum >= (PW+1)'(FIFO_DEPTH)) rd_sum = rd_sum - (PW+1)'(FIFO_DEPTH);
        wr_d  = fetch ? wr_sum[PW-1:0] : wr_q;
        rd_d  = pop ? rd_sum[PW-1:0] : rd_q;
        cnt_d = cnt_q + (fetch ? CW'(n) : CW'(0)) - (pop ? CW'(1) : CW'(0));
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len_clamped != LW'(0)) begin
                        state_d = S_FETCH;
                        cur_d   = base_addr;
                        rem_d   = len_clamped;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                if (fetch) begin
                    cur_d = cur_sum[AW-1:0];
                    rem_d = rem_q - LW'(n);
                    if (rem_d == LW'(0)) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && (cnt_q == CW'(1))) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // busy covers the done cycle of a real command, but not a zero-length one.
        busy_d = (state_d != S_IDLE) || ((state_q == S_DRAIN) && (state_d == S_IDLE));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            for (int k = 0; k < 4; k++) addr_q[k] <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            for (int k = 0; k < 4; k++) addr_q[k] <= addr_lane[k];
        end
    end

    always_ff @(posedge clk) begin
        if (fetch) begin
            for (int k = 0; k < 4; k++) begin
                if (3'(k) < n) mem_q[wr_idx[k][PW-1:0]] <= q_lane[k];
            end
        end
    end

endmodule
